myalu_exec_unit: RTL and testbench
==================================

MYALU_EXEC_UNIT -- requirements
Module: myalu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width, even and at least 8.
REQ-002 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port ARESETN, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port op_valid, input, 1 bit: the upstream register file is offering a command.
REQ-005 SHALL have port op_ready, output, 1 bit: the unit can accept a command.
REQ-006 SHALL have port opcode, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MULU, 6 DIVU; every other value is illegal.
REQ-007 SHALL have ports operand_a and operand_b, input, DATA_WIDTH each: the unsigned operands.
REQ-008 SHALL have port res_valid, output, 1 bit: a result is being presented.
REQ-009 SHALL have port res_ready, input, 1 bit: the upstream register file takes the result.
REQ-010 SHALL have port result_lo, output, DATA_WIDTH: the low result (the quotient for DIVU).
REQ-011 SHALL have port result_hi, output, DATA_WIDTH: the high product for MULU, the remainder for DIVU, otherwise 0.
REQ-012 SHALL have port status, output, 4 bits: {E,V,C,Z}, i.e. [3] error, [2] overflow, [1] carry/borrow, [0] zero.

Function
REQ-013 SHALL implement an FSM with three states, IDLE, EXEC and DONE.
REQ-014 SHALL drive op_ready from a register: 1 only in IDLE, 0 in EXEC and DONE.
REQ-015 SHALL accept a command when op_valid && op_ready on a rising edge, latching opcode and both operands at that edge.
REQ-016 SHALL leave operand or opcode changes after acceptance without effect.
REQ-017 SHALL, for ADD/SUB/AND/OR/XOR, illegal opcodes and DIVU by zero, go IDLE->DONE with res_valid=1 on the cycle after acceptance (latency 1).
REQ-018 SHALL, for MULU, go IDLE->EXEC and run a shift-add over DATA_WIDTH iterations, one per cycle, then enter DONE.
REQ-019 SHALL, for DIVU with a nonzero divisor, go IDLE->EXEC and run restoring division over DATA_WIDTH iterations, one per cycle, then enter DONE.
REQ-020 SHALL give MULU and DIVU (nonzero divisor) a latency of exactly DATA_WIDTH+1 cycles from acceptance to res_valid.
REQ-021 SHALL hold res_valid, result_lo, result_hi and status stable in DONE until res_ready=1.
REQ-022 SHALL, on a res_valid && res_ready edge, go DONE->IDLE, drop res_valid and set op_ready=1 on that same edge.
REQ-023 SHALL not accept a new command on the same edge as the result handshake; the earliest next acceptance is one cycle after it.
REQ-024 SHALL compute ADD as result_lo = (a+b) mod 2^W, with C = carry-out and V = signed overflow (operand signs equal, result sign differs).
REQ-025 SHALL compute SUB as result_lo = (a-b) mod 2^W, with C = 1 when a<b unsigned (borrow) and V = signed overflow (operand signs differ, result sign differs from a).
REQ-026 SHALL compute AND/OR/XOR bitwise on the full width, with C=0 and V=0.
REQ-027 SHALL compute MULU as the full 2W-bit product in {result_hi,result_lo}, with C=0 and V=0.
REQ-028 SHALL compute DIVU with nonzero b as quotient in result_lo and remainder in result_hi.
REQ-029 SHALL, for DIVU with b=0, return result_lo all ones, result_hi = a, E=1, C=0, V=0.
REQ-030 SHALL, for an illegal opcode, return result_lo=0, result_hi=0, E=1, C=0, V=0 and Z=1.
REQ-031 SHALL set Z=1 when result_lo==0, and for MULU only when both result_lo and result_hi are 0; for DIVU Z covers the quotient only.
REQ-032 SHALL set E=0 for every legal, non-faulting operation.
REQ-033 SHALL keep result_lo, result_hi and status at the values of the last completed operation outside DONE.

Reset
REQ-034 SHALL, while ARESETN=0, asynchronously force state=IDLE, op_ready=0, res_valid=0, result_lo=0, result_hi=0, status=0 and clear the iteration counter.
REQ-035 SHALL set op_ready=1 on the first rising ACLK edge with ARESETN=1.
REQ-036 SHALL, when reset is asserted mid-EXEC or mid-DONE, discard the operation without presenting a result, and resume correctly after release.

Verification
REQ-037 ADD 0xFFFFFFFF + 0x00000001 -> next cycle res_valid=1, result_lo=0, result_hi=0, status=0b0011 (C=1, Z=1).
REQ-038 SUB 0x80000000 - 0x00000001 -> result_lo=0x7FFFFFFF, status=0b0100 (V=1); SUB 1-2 -> result_lo=0xFFFFFFFF, status=0b0010.
REQ-039 MULU 0xFFFFFFFF * 0xFFFFFFFF -> res_valid exactly 33 cycles after acceptance, result_hi=0xFFFFFFFE, result_lo=0x00000001, status=0.
REQ-040 DIVU 100/7 -> result_lo=14, result_hi=2, latency 33; DIVU 5/0 -> latency 1, result_lo=0xFFFFFFFF, result_hi=5, status=0b1000.
REQ-041 Hold res_ready=0 for 10 cycles after res_valid with op_valid held high -> outputs stable, op_ready=0, no second acceptance; release res_ready -> op_ready=1 next cycle.
REQ-042 Pull ARESETN low 10 cycles into a MULU -> all outputs 0 immediately; after release, ADD 2+3 -> result_lo=5, status=0.

Source files
------------

// File: rtl/myalu_exec_unit.sv
// myalu_exec_unit: multi-cycle ALU with valid/ready command and result handshakes
module myalu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [3:0]            status
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          is_mul;
    logic [W-1:0]  m_r, hi_r, lo_r;
    logic [W:0]    sum, dif, t, r2, dd;
    logic          ok, f_e, f_v, f_c, n_z, accept, long_op;
    logic [W-1:0]  f_lo, f_hi, nhi, nlo;
    always_comb begin
        sum = {1'b0, operand_a} + {1'b0, operand_b};
        dif = {1'b0, operand_a} - {1'b0, operand_b};
        f_lo = opcode == 4'd0 ? sum[W-1:0] :
               opcode == 4'd1 ? dif[W-1:0] :
               opcode == 4'd2 ? operand_a & operand_b :
               opcode == 4'd3 ? operand_a | operand_b :
               opcode == 4'd4 ? operand_a ^ operand_b :
               opcode == 4'd6 ? {W{1'b1}} : {W{1'b0}};
        f_hi = opcode == 4'd6 ? operand_a : {W{1'b0}};
        f_e = opcode > 4'd4;
        f_c = opcode == 4'd0 ? sum[W] : opcode == 4'd1 ? dif[W] : 1'b0;
        f_v = opcode == 4'd0 ? (operand_a[W-1] == operand_b[W-1] && sum[W-1] != operand_a[W-1]) :
              opcode == 4'd1 ? (operand_a[W-1] != operand_b[W-1] && dif[W-1] != operand_a[W-1]) : 1'b0;
        // one shift-add step (mul) or one restoring-division step (div)
        t = lo_r[0] ? {1'b0, hi_r} + {1'b0, m_r} : {1'b0, hi_r};
        r2 = {hi_r, lo_r[W-1]};
        dd = r2 - {1'b0, m_r};
        ok = !dd[W];
        nhi = is_mul ? t[W:1] : (ok ? dd[W-1:0] : r2[W-1:0]);
        nlo = is_mul ? {t[0], lo_r[W-1:1]} : {lo_r[W-2:0], ok};
        n_z = nlo == '0 && (!is_mul || nhi == '0);
        accept = op_valid && op_ready;
        long_op = opcode == 4'd5 || (opcode == 4'd6 && operand_b != '0);
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            cnt <= '0;
            is_mul <= 1'b0;
            m_r <= '0;
            hi_r <= '0;
            lo_r <= '0;
            op_ready <= 1'b0;
            res_valid <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            status <= '0;
        end else begin
            case (state)
                IDLE: begin
                    op_ready <= !accept;
                    if (accept && long_op) begin
                        state <= EXEC;
                        cnt <= '0;
                        is_mul <= opcode == 4'd5;
                        m_r <= opcode == 4'd5 ? operand_a : operand_b;
                        lo_r <= opcode == 4'd5 ? operand_b : operand_a;
                        hi_r <= '0;
                    end else if (accept) begin
                        state <= DONE;
                        res_valid <= 1'b1;
                        result_lo <= f_lo;
                        result_hi <= f_hi;
                        status <= {f_e, f_v, f_c, f_lo == '0};
                    end
                end
                EXEC: begin
                    hi_r <= nhi;
                    lo_r <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                        res_valid <= 1'b1;
                        result_lo <= nlo;
                        result_hi <= nhi;
                        status <= {3'b000, n_z};
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                        res_valid <= 1'b0;
                        op_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_myalu_exec_unit.sv
// tb_myalu_exec_unit: directed vector table plus handshake and reset sequences
module tb_myalu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  opcode = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result_lo, result_hi;
    logic [3:0]  status;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [3:0]  opc;
        logic [31:0] a, b, lo, hi;
        logic [3:0]  st;
        int          lat;
    } vec_t;
    vec_t vecs[16];
    always #5 clk = ~clk;
    myalu_exec_unit #(.DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESETN(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .res_valid(res_valid), .res_ready(res_ready), .result_lo(result_lo),
        .result_hi(result_hi), .status(status)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic run(input vec_t v, input string name);
        int n = 0;
        int lat;
        @(negedge clk);
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " ready"}, 64'(op_ready), 64'd1);
        opcode = v.opc;
        operand_a = v.a;
        operand_b = v.b;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        operand_a = ~v.a;
        operand_b = v.b ^ 32'h5A5A_0F0F;
        opcode = v.opc ^ 4'h3;
        lat = 1;
        while (!res_valid && lat < 100) begin
            chk({name, " busy_ready"}, 64'(op_ready), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(v.lat));
        chk({name, " lo"}, 64'(result_lo), 64'(v.lo));
        chk({name, " hi"}, 64'(result_hi), 64'(v.hi));
        chk({name, " status"}, 64'(status), 64'(v.st));
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({name, " post_valid"}, 64'(res_valid), 64'd0);
        chk({name, " post_ready"}, 64'(op_ready), 64'd1);
        chk({name, " keep_lo"}, 64'(result_lo), 64'(v.lo));
    endtask
    initial begin
        logic [31:0] s_lo, s_hi;
        logic [3:0]  s_st;
        int n;
        vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 4'b0011, 1};
        vecs[1]  = '{4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 4'b0100, 1};
        vecs[2]  = '{4'd1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0, 4'b0010, 1};
        vecs[3]  = '{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 4'b0100, 1};
        vecs[4]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 4'b0000, 1};
        vecs[5]  = '{4'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 32'h0, 4'b0000, 1};
        vecs[6]  = '{4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0, 4'b0001, 1};
        vecs[7]  = '{4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0000, 33};
        vecs[8]  = '{4'd5, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0, 4'b0001, 33};
        vecs[9]  = '{4'd5, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 4'b0000, 33};
        vecs[10] = '{4'd6, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 33};
        vecs[11] = '{4'd6, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 4'b1000, 1};
        vecs[12] = '{4'd6, 32'd3, 32'd10, 32'd0, 32'd3, 4'b0001, 33};
        vecs[13] = '{4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 4'b1001, 1};
        vecs[14] = '{4'd15, 32'hFFFF_FFFF, 32'h1, 32'd0, 32'd0, 4'b1001, 1};
        vecs[15] = '{4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 4'b0001, 1};
        #21;
        chk("rst_ready", 64'(op_ready), 64'd0);
        chk("rst_outs", {1'b0, res_valid, result_lo, result_hi[29:0]}, 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_ready", 64'(op_ready), 64'd1);
        for (int i = 0; i < 16; i++) run(vecs[i], $sformatf("vec%0d", i));
        // hold the result with op_valid kept high; no second acceptance
        @(negedge clk);
        opcode = 4'd0;
        operand_a = 32'd2;
        operand_b = 32'd3;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_first", 64'(res_valid), 64'd1);
        s_lo = result_lo;
        s_hi = result_hi;
        s_st = status;
        chk("hold_val", 64'(s_lo), 64'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", {res_valid, op_ready, s_st, result_lo, result_hi[25:0]},
                {1'b1, 1'b0, 4'b0000, s_lo, s_hi[25:0]});
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ready", 64'(op_ready), 64'd1);
        chk("release_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("reaccept_valid", 64'(res_valid), 64'd1);
        chk("reaccept_ready", 64'(op_ready), 64'd0);
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("drain_valid", 64'(res_valid), 64'd0);
        // reset in the middle of a multiply
        @(negedge clk);
        opcode = 4'd5;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'h1234_5678;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {res_valid, op_ready, status, result_lo[25:0]}, 64'd0);
        chk("midrst_hi", 64'(result_hi), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrst_no_result", 64'(res_valid), 64'd0);
        run('{4'd0, 32'd2, 32'd3, 32'd5, 32'd0, 4'b0000, 1}, "after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
